bram_output_checker: RTL and testbench
======================================

Name: bram_output_checker

Overview:
- Downstream stage for the 512x32 BRAM test harness.
- Consumes the address and write-enable stream driven into both BRAM instances, plus the read data returned by the behavioural model and by the implementation.
- Delays each access by the BRAM read latency and compares the two data words for that access.
- Keeps compare and mismatch counts, plus a snapshot of the first mismatch, so the bench can end with one pass/fail check instead of scanning per-cycle prints.

Parameters:
- AW, 9, address width.
- DW, 32, data width.
- LATENCY, 1, read latency of the BRAM in cycles, legal range 1..4.
- CHECK_WRITES, 0, if 1 also compare outputs on write cycles; if 0 compare only on reads.

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high.
- clear  input  1  synchronous soft clear of counters, snapshot and state; pipeline unaffected.
- en  input  1  access valid this cycle; addr/wen sampled only when high.
- addr  input  AW  address presented to both BRAMs this cycle.
- wen  input  1  write enable presented to both BRAMs this cycle.
- behav_q  input  DW  behavioural BRAM read data.
- impl_q  input  DW  implementation BRAM read data.
- state  output  2  0 IDLE, 1 RUN, 2 FAIL.
- compare_count  output  32  number of comparisons performed, wraps modulo 2^32.
- mismatch_count  output  16  number of mismatches, saturates at 16'hFFFF.
- mismatch  output  1  sticky, high once any mismatch is seen.
- first_addr  output  AW  address of the first mismatch.
- first_behav  output  DW  behavioural data at the first mismatch.
- first_impl  output  DW  implementation data at the first mismatch.

Behaviour:
- Reset (clock edge with reset=1):
  - All outputs 0; state IDLE.
  - Delay pipeline valid bits cleared, so no comparison occurs during the LATENCY cycles after reset deasserts.
- Delay pipeline:
  - LATENCY stages of {valid, addr, wen}.
  - Stage 0 loads valid=en (with addr, wen) every cycle; there is no stall.
  - A tap is the stage-LATENCY entry.
- Comparison enable: the tap is compared against behav_q/impl_q in the current cycle when:
  - tap.valid=1, and
  - tap.wen=0 or CHECK_WRITES=1.
- Counters on a compare cycle:
  - compare_count increments by 1.
  - If behav_q != impl_q (full DW bitwise, X counts as mismatch in simulation via !==), mismatch_count increments unless already 16'hFFFF.
- FSM, all transitions registered:
  - IDLE -> RUN on the first cycle with en=1.
  - RUN -> FAIL on a compare cycle with mismatch.
  - FAIL is sticky until reset or clear.
  - Comparing and counting continue in FAIL.
- First-mismatch snapshot:
  - first_addr/first_behav/first_impl load only on the mismatch that sets mismatch from 0 to 1.
  - Later mismatches do not overwrite them.
  - mismatch and state FAIL are visible the cycle after the compare cycle.
- Outputs registered: counters and snapshot update one cycle after the compare cycle.
- clear=1 (reset=0):
  - Counters, mismatch and snapshot go to 0; state goes to IDLE.
  - If en=1 in the same cycle, state goes to RUN instead.
  - Pipeline contents kept; a compare arriving in the clear cycle is discarded, and clear wins.
- reset during operation: identical to power-on reset; in-flight pipeline entries dropped.
- Address wrap (e.g. 7 -> 0 in the harness): no special handling; addr is carried verbatim.
- en=0 cycles: create bubbles, no comparison LATENCY cycles later.

Test Plan:
- Reset 3 cycles, then en=1 with addr 0..7, wen=1 (writes 0x10..0x17), then addr 0..7 with wen=0 and both q paths equal -> after pipeline drain: compare_count=8, mismatch_count=0, state=RUN, mismatch=0.
- Same sequence, with impl_q forced to 0xDEADBEEF on the read of addr 3 (behav 0x13) -> mismatch=1, state=FAIL, first_addr=3, first_behav=0x00000013, first_impl=0xDEADBEEF, mismatch_count=1.
- Two mismatches at addr 3 then addr 5 -> mismatch_count=2, snapshot still addr 3 data; then pulse clear -> all counters 0, state=IDLE, snapshot 0.
- LATENCY=2, impl_q delayed one extra cycle relative to behav_q on incrementing data -> every read compare mismatches; with correct alignment -> 0 mismatches.
- CHECK_WRITES=1, 8 writes plus 8 reads -> compare_count=16. With CHECK_WRITES=0 -> compare_count=8.
- Assert reset mid-sequence after a mismatch -> next cycle all outputs 0, state IDLE; the first LATENCY cycles after reset produce no compare even if the q inputs differ.

Source files
------------

// File: rtl/bram_output_checker.sv
// Compares behavioural and implementation BRAM read data, aligned to the BRAM read
// latency, and keeps compare/mismatch counters plus a snapshot of the first mismatch.
module bram_output_checker #(
  parameter int AW           = 9,
  parameter int DW           = 32,
  parameter int LATENCY      = 1,
  parameter int CHECK_WRITES = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic          wen,
  input  logic [DW-1:0] behav_q,
  input  logic [DW-1:0] impl_q,
  output logic [1:0]    state,
  output logic [31:0]   compare_count,
  output logic [15:0]   mismatch_count,
  output logic          mismatch,
  output logic [AW-1:0] first_addr,
  output logic [DW-1:0] first_behav,
  output logic [DW-1:0] first_impl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LATENCY-1:0] vld_p_q, vld_p_d;
  logic [LATENCY-1:0] wen_p_q, wen_p_d;
  logic [AW-1:0]   addr_p_q [LATENCY];
  logic [AW-1:0]   addr_p_d [LATENCY];
  logic [31:0]     compare_count_q, compare_count_d;
  logic [15:0]     mismatch_count_q, mismatch_count_d;
  logic            mismatch_q, mismatch_d;
  logic [AW-1:0]   first_addr_q, first_addr_d;
  logic [DW-1:0]   first_behav_q, first_behav_d;
  logic [DW-1:0]   first_impl_q, first_impl_d;
  logic            cmp, miss;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Access delay line: stage 0 captures this cycle's access, the last stage is the tap
  always_comb begin
    vld_p_d     = vld_p_q;
    wen_p_d     = wen_p_q;
    addr_p_d    = addr_p_q;
    vld_p_d[0]  = en;
    wen_p_d[0]  = wen;
    addr_p_d[0] = addr;
    for (int i = 1; i < LATENCY; i++) begin
      vld_p_d[i]  = vld_p_q[i-1];
      wen_p_d[i]  = wen_p_q[i-1];
      addr_p_d[i] = addr_p_q[i-1];
    end
  end

  // Compare stage: tap aligned with the read data presented this cycle
  always_comb begin
    cmp  = vld_p_q[LATENCY-1] && (!wen_p_q[LATENCY-1] || (CHECK_WRITES != 0));
    miss = cmp && (behav_q !== impl_q);
  end

  always_comb begin
    state_d          = state_q;
    compare_count_d  = compare_count_q;
    mismatch_count_d = mismatch_count_q;
    mismatch_d       = mismatch_q;
    first_addr_d     = first_addr_q;
    first_behav_d    = first_behav_q;
    first_impl_d     = first_impl_q;
    if (clear) begin
      state_d          = en ? RUN : IDLE;
      compare_count_d  = '0;
      mismatch_count_d = '0;
      mismatch_d       = 1'b0;
      first_addr_d     = '0;
      first_behav_d    = '0;
      first_impl_d     = '0;
    end else begin
      if (cmp) compare_count_d = compare_count_q + 32'd1;
      if (miss) begin
        mismatch_count_d = sat_inc16(mismatch_count_q);
        mismatch_d       = 1'b1;
        if (!mismatch_q) begin
          first_addr_d  = addr_p_q[LATENCY-1];
          first_behav_d = behav_q;
          first_impl_d  = impl_q;
        end
      end
      // A mismatch surfacing while IDLE (entries left over from a clear) still flags FAIL
      case (state_q)
        IDLE:    if (miss) state_d = FAIL; else if (en) state_d = RUN;
        RUN:     if (miss) state_d = FAIL;
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      vld_p_q          <= '0;
      compare_count_q  <= '0;
      mismatch_count_q <= '0;
      mismatch_q       <= 1'b0;
      first_addr_q     <= '0;
      first_behav_q    <= '0;
      first_impl_q     <= '0;
    end else begin
      state_q          <= state_d;
      vld_p_q          <= vld_p_d;
      compare_count_q  <= compare_count_d;
      mismatch_count_q <= mismatch_count_d;
      mismatch_q       <= mismatch_d;
      first_addr_q     <= first_addr_d;
      first_behav_q    <= first_behav_d;
      first_impl_q     <= first_impl_d;
    end
  end

  // Address/wen ride along without reset; only the valid bits gate their use
  always_ff @(posedge clock) begin
    wen_p_q  <= wen_p_d;
    addr_p_q <= addr_p_d;
  end

  assign state          = state_q;
  assign compare_count  = compare_count_q;
  assign mismatch_count = mismatch_count_q;
  assign mismatch       = mismatch_q;
  assign first_addr     = first_addr_q;
  assign first_behav    = first_behav_q;
  assign first_impl     = first_impl_q;

endmodule

// File: tb/tb_bram_output_checker.sv
// Directed bench: three checker instances (latency 1, latency 2, write checking) fed
// from a simple BRAM model with controllable corruption of the implementation data.
module tb_bram_output_checker;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_BAD  = 2'd2;

  logic        clock = 1'b0;
  logic        reset, clear, en, wen, corrupt, force_diff, misalign;
  logic [8:0]  addr;
  logic [31:0] wdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  // BRAM model: write-first, output holds when idle
  logic [31:0] mem [0:511];
  logic [31:0] m_q1, m_q2a, m_q2b, m_q2c;
  logic        c_q1;
  logic [31:0] rd;
  always @(posedge clock) begin
    rd = en ? (wen ? wdata : mem[addr]) : m_q1;
    if (en && wen) mem[addr] <= wdata;
    m_q1  <= rd;
    m_q2a <= en ? rd : m_q2a;
    m_q2b <= m_q2a;
    m_q2c <= m_q2b;
    c_q1  <= en & corrupt;
  end

  logic [31:0] impl0, impl1;
  assign impl0 = (c_q1 || force_diff) ? 32'hDEADBEEF : m_q1;
  assign impl1 = misalign ? m_q2c : m_q2b;

  logic [1:0]  st0, st1, st2;
  logic [31:0] cc0, cc1, cc2;
  logic [15:0] mc0, mc1, mc2;
  logic        mm0, mm1, mm2;
  logic [8:0]  fa0, fa1, fa2;
  logic [31:0] fb0, fb1, fb2, fi0, fi1, fi2;

  bram_output_checker #(.AW(9), .DW(32), .LATENCY(1), .CHECK_WRITES(0)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .addr(addr), .wen(wen),
    .behav_q(m_q1), .impl_q(impl0), .state(st0), .compare_count(cc0),
    .mismatch_count(mc0), .mismatch(mm0), .first_addr(fa0), .first_behav(fb0),
    .first_impl(fi0));

  bram_output_checker #(.AW(9), .DW(32), .LATENCY(2), .CHECK_WRITES(0)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .addr(addr), .wen(wen),
    .behav_q(m_q2b), .impl_q(impl1), .state(st1), .compare_count(cc1),
    .mismatch_count(mc1), .mismatch(mm1), .first_addr(fa1), .first_behav(fb1),
    .first_impl(fi1));

  bram_output_checker #(.AW(9), .DW(32), .LATENCY(1), .CHECK_WRITES(1)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .addr(addr), .wen(wen),
    .behav_q(m_q1), .impl_q(m_q1), .state(st2), .compare_count(cc2),
    .mismatch_count(mc2), .mismatch(mm2), .first_addr(fa2), .first_behav(fb2),
    .first_impl(fi2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [8:0] a, input logic w,
                      input logic [31:0] d, input logic c);
    en = e; addr = a; wen = w; wdata = d; corrupt = c;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_state"}, 64'(st0), 64'(ST_IDLE));
    chk({tag, "_cc"}, 64'(cc0), 64'd0);
    chk({tag, "_mc"}, 64'(mc0), 64'd0);
    chk({tag, "_mm"}, 64'(mm0), 64'd0);
    chk({tag, "_fa"}, 64'(fa0), 64'd0);
    chk({tag, "_fb"}, 64'(fb0), 64'd0);
    chk({tag, "_fi"}, 64'(fi0), 64'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; force_diff = 1'b0; misalign = 1'b0;
    en = 1'b0; wen = 1'b0; addr = '0; wdata = '0; corrupt = 1'b0;
    @(negedge clock);
    idle(3);
    reset = 1'b0;
    chk_zero0("rst");
    chk("rst_u1_cc", 64'(cc1), 64'd0);

    // Aligned writes then reads
    for (int i = 0; i < 8; i++) step(1'b1, 9'(i), 1'b1, 32'h10 + 32'(i), 1'b0);
    chk("run_state", 64'(st0), 64'(ST_RUN));
    for (int i = 0; i < 8; i++) step(1'b1, 9'(i), 1'b0, 32'd0, 1'b0);
    idle(3);
    chk("t1_cc", 64'(cc0), 64'd8);
    chk("t1_mc", 64'(mc0), 64'd0);
    chk("t1_mm", 64'(mm0), 64'd0);
    chk("t1_state", 64'(st0), 64'(ST_RUN));
    chk("t1_u1_cc", 64'(cc1), 64'd8);
    chk("t1_u1_mc", 64'(mc1), 64'd0);
    chk("t1_u2_cc", 64'(cc2), 64'd16);
    chk("t1_u2_mc", 64'(mc2), 64'd0);

    // Corrupt read of addr 3; latency-2 instance sees misaligned implementation data
    misalign = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 9'(i), 1'b0, 32'd0, i == 3);
    idle(3);
    misalign = 1'b0;
    chk("t2_mm", 64'(mm0), 64'd1);
    chk("t2_state", 64'(st0), 64'(ST_BAD));
    chk("t2_fa", 64'(fa0), 64'd3);
    chk("t2_fb", 64'(fb0), 64'h13);
    chk("t2_fi", 64'(fi0), 64'hDEADBEEF);
    chk("t2_mc", 64'(mc0), 64'd1);
    chk("t2_cc", 64'(cc0), 64'd16);
    chk("t2_u1_mc", 64'(mc1), 64'd8);
    chk("t2_u1_state", 64'(st1), 64'(ST_BAD));
    chk("t2_u2_cc", 64'(cc2), 64'd24);

    // Clear, then two mismatches: snapshot keeps the first
    clear = 1'b1; idle(1); clear = 1'b0;
    chk_zero0("clr1");
    for (int i = 0; i < 8; i++) step(1'b1, 9'(i), 1'b0, 32'd0, (i == 3) || (i == 5));
    idle(2);
    chk("t3_mc", 64'(mc0), 64'd2);
    chk("t3_cc", 64'(cc0), 64'd8);
    chk("t3_fa", 64'(fa0), 64'd3);
    chk("t3_fb", 64'(fb0), 64'h13);
    chk("t3_state", 64'(st0), 64'(ST_BAD));
    clear = 1'b1; idle(1); clear = 1'b0;
    chk_zero0("clr2");

    // Clear with en=1: compare in clear cycle dropped, state goes to RUN
    step(1'b1, 9'd1, 1'b0, 32'd0, 1'b0);
    clear = 1'b1;
    step(1'b1, 9'd2, 1'b0, 32'd0, 1'b0);
    clear = 1'b0;
    chk("clren_state", 64'(st0), 64'(ST_RUN));
    chk("clren_cc", 64'(cc0), 64'd0);
    idle(1);
    chk("clren_cc2", 64'(cc0), 64'd1);

    // Reset after a mismatch drops in-flight entries
    step(1'b1, 9'd0, 1'b0, 32'd0, 1'b1);
    idle(1);
    chk("t4_mm", 64'(mm0), 64'd1);
    step(1'b1, 9'd1, 1'b0, 32'd0, 1'b1);
    reset = 1'b1;
    step(1'b1, 9'd2, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    chk_zero0("t4_rst");
    force_diff = 1'b1;
    idle(1);
    force_diff = 1'b0;
    chk("t4_post_cc", 64'(cc0), 64'd0);
    chk("t4_post_mm", 64'(mm0), 64'd0);

    // Long mismatching stream: mismatch count saturates, compare count keeps going
    force_diff = 1'b1;
    for (int i = 0; i < 65537; i++) step(1'b1, 9'(i), 1'b0, 32'd0, 1'b0);
    idle(1);
    force_diff = 1'b0;
    chk("sat_mc", 64'(mc0), 64'hFFFF);
    chk("sat_cc", 64'(cc0), 64'd65537);
    chk("sat_fa", 64'(fa0), 64'd0);
    chk("sat_fb", 64'(fb0), 64'h10);
    chk("sat_fi", 64'(fi0), 64'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
